// File: rtl/serial_nibble_adder.sv
// Multi-cycle W-bit adder: feeds a 4-bit adder one nibble per clock, LSB first,
// with a registered inter-nibble carry and a one-cycle done pulse on completion.
module serial_nibble_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] operand_a,
  input  logic [4*NIBBLES-1:0] operand_b,
  input  logic                 carry_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [0:0] {StIdle, StAdd} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, acc_q;
  logic            carry_q;
  logic [IdxW-1:0] idx_q;

  logic [4:0]      nib_sum;
  logic [W-1:0]    acc_next;
  logic            nib_ovf;

  // The 4-bit full-adder slice driven by the low nibbles and the carry register.
  always_comb begin
    nib_sum  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    // Shift form keeps NIBBLES == 1 legal (no empty slice of acc_q).
    acc_next = (acc_q >> 4) | (W'(nib_sum[3:0]) << (W - 4));
    nib_ovf  = (a_q[3] == b_q[3]) && (nib_sum[3] != a_q[3]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= operand_a;
            b_q     <= operand_b;
            carry_q <= carry_in;
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          acc_q   <= acc_next;
          carry_q <= nib_sum[4];
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            result    <= acc_next;
            carry_out <= nib_sum[4];
            overflow  <= nib_ovf;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder with NIBBLES = 4.
module tb_serial_nibble_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] operand_a, operand_b;
  logic         carry_in;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  serial_nibble_adder #(.NIBBLES(NIBBLES)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent model: full-width add, overflow from operand/sum sign bits.
  task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t       e;
    logic [W:0] s;
    s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.res = s[W-1:0];
    e.co  = s[W];
    e.ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    e.due = cyc + NIBBLES + 1;
    sb.push_back(e);
  endtask

  // Monitor: compare on done, flag unexpected or missing completions.
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("carry_out", 32'(carry_out), 32'(e.co));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("latency", cyc, e.due);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      check("done_timeout", 32'(done), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    carry_in  = ci;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(negedge clock);
    drive(a, b, ci);
    push_expect(a, b, ci);
    @(negedge clock);
    start     = 1'b0;
    operand_a = '1;
    operand_b = '1;
    check("busy_after_start", 32'(busy), 32'd1);
    drain();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    carry_in  = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0);
    run_op(16'h0F0F, 16'h00F0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clock);
    drive(16'h0001, 16'h0001, 1'b0);
    push_expect(16'h0001, 16'h0001, 1'b0);
    @(negedge clock);
    drive(16'hAAAA, 16'h5555, 1'b0);
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clock);
    check("done_seen", 32'(done), 32'd1);
    drive(16'hAAAA, 16'h5555, 1'b0);
    push_expect(16'hAAAA, 16'h5555, 1'b0);
    @(negedge clock);
    start = 1'b0;
    check("busy_b2b", 32'(busy), 32'd1);
    drain();

    // Asynchronous reset mid-operation discards the add.
    @(negedge clock);
    drive(16'h1234, 16'h1111, 1'b0);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_result", 32'(result), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'd0);
    run_op(16'h0100, 16'h0200, 1'b0);

    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
